// File: rtl/mure_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mure_pkg : shared uop types, scheduler state and helper functions  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package mure_pkg;

    typedef enum logic [2:0] {
        ITYPE_STD  = 3'd0,
        ITYPE_EXC  = 3'd1,
        ITYPE_INT  = 3'd2,
        ITYPE_ERET = 3'd3,
        ITYPE_NTB  = 3'd4,
        ITYPE_TB   = 3'd5,
        ITYPE_UIJ  = 3'd6
    } itype_e;

    typedef struct packed {
        itype_e      itype;
        logic [31:0] pc;
    } uop_entry_s;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DROP   = 2'd1,
        RESYNC = 2'd2
    } sched_state_e;

    typedef struct packed {
        uop_entry_s uop;
        logic       resync;
        logic       disc;
    } sched_entry_s;

    function automatic logic is_disc(input itype_e t);
        logic r;
        case (t)
            ITYPE_EXC, ITYPE_INT, ITYPE_ERET: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uop_issue_sched_compactor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uop_lane_compactor : packs valid commit lanes in lane order        |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module uop_lane_compactor
    import mure_pkg::*;
#(
    parameter int unsigned NrRetiredInstr = 4
) (
    input  logic       [NrRetiredInstr-1:0]     ivalids_i,
    input  uop_entry_s [NrRetiredInstr-1:0]     uops_i,
    output uop_entry_s [NrRetiredInstr-1:0]     packed_o,
    output logic       [$clog2(NrRetiredInstr):0] n_in_o
);

    localparam int unsigned IW = $clog2(NrRetiredInstr);

    logic [IW:0] idx;

    always_comb begin
        packed_o = '0;
        idx      = '0;
        for (int i = 0; i < int'(NrRetiredInstr); i++) begin
            if (ivalids_i[i]) begin
                packed_o[idx[IW-1:0]] = uops_i[i];
                idx = idx + 1'b1;
            end
        end
        n_in_o = idx;
    end

endmodule
`default_nettype wire

// File: rtl/uop_issue_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uop_issue_sched : commit-to-trace uop buffer, drop-whole-group      |
// | overflow with resync marking. Optional stats: UOP_ISSUE_SCHED_STATS_EN |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module uop_issue_sched
    import mure_pkg::*;
#(
    parameter int unsigned NrRetiredInstr = 4,
    parameter int unsigned Depth          = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic       [NrRetiredInstr-1:0] ivalids_i,
    input  uop_entry_s [NrRetiredInstr-1:0] uops_i,
    input  logic                            flush_i,
    input  logic                            ready_i,
    output logic                            valid_o,
    output uop_entry_s                      uop_o,
    output logic                            resync_o,
    output logic                            disc_o,
    output logic                            overflow_o,
    output logic       [$clog2(Depth):0]    count_o,
    output logic       [15:0]               drop_cnt_o,
    output logic       [$clog2(Depth):0]    hwm_o
);

    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned NW = $clog2(NrRetiredInstr) + 1;

    uop_entry_s [NrRetiredInstr-1:0] packed_uops;
    logic [NW-1:0]                   n_in;

    uop_lane_compactor #(
        .NrRetiredInstr (NrRetiredInstr)
    ) u_compactor (
        .ivalids_i (ivalids_i),
        .uops_i    (uops_i),
        .packed_o  (packed_uops),
        .n_in_o    (n_in)
    );

    sched_entry_s [Depth-1:0] mem_q, mem_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    sched_state_e             state_q, state_d;
    logic                     overflow_q, overflow_d;

    logic          pop, accept, drop_grp, set_rs, nonempty, fits;
    logic [PW-1:0] widx;

    assign nonempty = (n_in != '0);
    // Fit uses the registered occupancy only; a same-cycle pop earns no credit.
    assign fits     = (CW'(n_in) <= (CW'(Depth) - count_q));
    assign pop      = (count_q != '0) && ready_i;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;
        accept     = 1'b0;
        drop_grp   = 1'b0;
        set_rs     = 1'b0;
        widx       = '0;
        if (flush_i) begin
            state_d    = RUN;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (nonempty) begin
                        if (fits) accept   = 1'b1;
                        else      drop_grp = 1'b1;
                    end
                end
                DROP: drop_grp = nonempty;
                RESYNC: begin
                    accept = nonempty;
                    set_rs = nonempty;
                end
                default: ;
            endcase

            count_d = count_q + (accept ? CW'(n_in) : CW'(0)) - CW'(pop);
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

            if (accept) begin
                for (int k = 0; k < int'(NrRetiredInstr); k++) begin
                    if (k < int'(n_in)) begin
                        widx                = wr_ptr_q + PW'(k);
                        mem_d[widx].uop     = packed_uops[k];
                        mem_d[widx].resync  = set_rs && (k == 0);
                        mem_d[widx].disc    = is_disc(packed_uops[k].itype);
                    end
                end
                wr_ptr_d = wr_ptr_q + PW'(n_in);
            end

            if (drop_grp) overflow_d = 1'b1;

            case (state_q)
                RUN:     if (drop_grp)        state_d = DROP;
                DROP:    if (count_d == '0)   state_d = RESYNC;
                RESYNC:  if (accept)          state_d = RUN;
                default:                      state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            mem_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign valid_o    = (count_q != '0);
    assign uop_o      = valid_o ? mem_q[rd_ptr_q].uop : '0;
    assign resync_o   = valid_o && mem_q[rd_ptr_q].resync;
    assign disc_o     = valid_o && mem_q[rd_ptr_q].disc;
    assign overflow_o = overflow_q;
    assign count_o    = count_q;

`ifdef UOP_ISSUE_SCHED_STATS_EN
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] hwm_q, hwm_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        hwm_d      = hwm_q;
        if (flush_i) begin
            drop_cnt_d = '0;
            hwm_d      = '0;
        end else begin
            if (drop_grp && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
            if (count_d > hwm_q) hwm_d = count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
            hwm_q      <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            hwm_q      <= hwm_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
    assign hwm_o      = hwm_q;
`else
    assign drop_cnt_o = '0;
    assign hwm_o      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uop_issue_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uop_issue_sched : scoreboard bench for uop_issue_sched           |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_uop_issue_sched;
    import mure_pkg::*;

    localparam int N = 4;
    localparam int D = 8;

    logic             clk_i  = 1'b0;
    logic             rst_ni = 1'b0;
    logic [N-1:0]     ivalids_i;
    uop_entry_s [N-1:0] uops_i;
    logic             flush_i;
    logic             ready_i;
    logic             valid_o;
    uop_entry_s       uop_o;
    logic             resync_o;
    logic             disc_o;
    logic             overflow_o;
    logic [3:0]       count_o;
    logic [15:0]      drop_cnt_o;
    logic [3:0]       hwm_o;

    always #5 clk_i = ~clk_i;

    uop_issue_sched #(
        .NrRetiredInstr (N),
        .Depth          (D)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ivalids_i  (ivalids_i),
        .uops_i     (uops_i),
        .flush_i    (flush_i),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .uop_o      (uop_o),
        .resync_o   (resync_o),
        .disc_o     (disc_o),
        .overflow_o (overflow_o),
        .count_o    (count_o),
        .drop_cnt_o (drop_cnt_o),
        .hwm_o      (hwm_o)
    );

    typedef struct {
        logic [31:0] pc;
        itype_e      itype;
        logic        rs;
    } exp_t;

    exp_t   sb[$];
    int     pass_cnt  = 0;
    int     total_cnt = 0;
    int     disc_seen = 0;
    itype_e lane_itype[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: a handshake seen here is a pop on the next rising edge.
    always @(negedge clk_i) begin : mon
        exp_t e;
        logic exp_disc;
        if (rst_ni && !flush_i && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_uop: got pc %0h expected none", uop_o.pc);
            end else begin
                e = sb.pop_front();
                exp_disc = (e.itype == ITYPE_EXC) || (e.itype == ITYPE_INT) || (e.itype == ITYPE_ERET);
                chk("uop_pc", uop_o.pc, e.pc);
                chk("uop_itype", 32'(uop_o.itype), 32'(e.itype));
                chk("resync", 32'(resync_o), 32'(e.rs));
                chk("disc", 32'(disc_o), 32'(exp_disc));
                if (disc_o) disc_seen++;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [N-1:0] v, input logic [31:0] pc0, input bit acc, input bit rs);
        bit first;
        first = 1'b1;
        for (int i = 0; i < N; i++) begin
            uops_i[i].pc    = pc0 + 32'(i);
            uops_i[i].itype = lane_itype[i];
            if (v[i] && acc) begin
                sb.push_back('{pc0 + 32'(i), lane_itype[i], rs && first});
                first = 1'b0;
            end
        end
        ivalids_i = v;
        step();
        ivalids_i = '0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 40 && count_o != 0; n++) step();
        chk(name, 32'(count_o), 32'd0);
    endtask

    initial begin
        logic [15:0] exp_drop;
        logic [3:0]  exp_hwm;
        ivalids_i = '0;
        uops_i    = '0;
        flush_i   = 1'b0;
        ready_i   = 1'b0;
        for (int i = 0; i < N; i++) lane_itype[i] = ITYPE_STD;

        // Reset state
        step();
        step();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_overflow", 32'(overflow_o), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
        rst_ni = 1'b1;

        // Sparse lanes compacted in order
        ready_i = 1'b1;
        issue(4'b1011, 32'h10, 1'b1, 1'b0);
        chk("sparse_cnt3", 32'(count_o), 32'd3);
        step(); chk("sparse_cnt2", 32'(count_o), 32'd2);
        step(); chk("sparse_cnt1", 32'(count_o), 32'd1);
        step(); chk("sparse_cnt0", 32'(count_o), 32'd0);

        // Fill, overflow, drop during drain, resync
        ready_i = 1'b0;
        issue(4'b1111, 32'h20, 1'b1, 1'b0);
        issue(4'b1111, 32'h30, 1'b1, 1'b0);
        chk("full_count", 32'(count_o), 32'd8);
        chk("full_valid", 32'(valid_o), 32'd1);
        issue(4'b0001, 32'h40, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        chk("ovf_count", 32'(count_o), 32'd8);
        ready_i = 1'b1;
        step();
        chk("drain_count7", 32'(count_o), 32'd7);
        issue(4'b1111, 32'h50, 1'b0, 1'b0);
        issue(4'b1111, 32'h58, 1'b0, 1'b0);
        chk("drop_drain_count", 32'(count_o), 32'd5);
        drain("drain_after_drop");
        issue(4'b0000, 32'h5C, 1'b0, 1'b0);
        issue(4'b0011, 32'h60, 1'b1, 1'b1);
        drain("drain_resync");
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
`ifdef UOP_ISSUE_SCHED_STATS_EN
        exp_drop = 16'd3;
        exp_hwm  = 4'd8;
`else
        exp_drop = 16'd0;
        exp_hwm  = 4'd0;
`endif
        chk("drop_cnt", 32'(drop_cnt_o), 32'(exp_drop));
        chk("hwm", 32'(hwm_o), 32'(exp_hwm));

        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_ovf_clr", 32'(overflow_o), 32'd0);
        chk("flush_drop_clr", 32'(drop_cnt_o), 32'd0);
        chk("flush_hwm_clr", 32'(hwm_o), 32'd0);

        // Same-cycle pop is not credited toward the fit test
        ready_i = 1'b0;
        issue(4'b1111, 32'h70, 1'b1, 1'b0);
        issue(4'b0011, 32'h74, 1'b1, 1'b0);
        chk("cnt6", 32'(count_o), 32'd6);
        ready_i = 1'b1;
        issue(4'b0011, 32'h78, 1'b1, 1'b0);
        chk("pop_enq_cnt7", 32'(count_o), 32'd7);
        chk("pop_enq_noovf", 32'(overflow_o), 32'd0);
        issue(4'b0111, 32'h7A, 1'b0, 1'b0);
        chk("pop_enq3_cnt6", 32'(count_o), 32'd6);
        chk("pop_enq3_ovf", 32'(overflow_o), 32'd1);
        drain("drain_pop_enq");

        // Flush with a group present
        ready_i = 1'b0;
        issue(4'b1111, 32'h80, 1'b1, 1'b1);
        issue(4'b0001, 32'h84, 1'b1, 1'b0);
        chk("pre_flush_cnt5", 32'(count_o), 32'd5);
        chk("pre_flush_ovf", 32'(overflow_o), 32'd1);
        flush_i = 1'b1;
        issue(4'b1111, 32'h90, 1'b0, 1'b0);
        flush_i = 1'b0;
        sb.delete();
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_ovf", 32'(overflow_o), 32'd0);
        chk("flush_valid", 32'(valid_o), 32'd0);

        // Three groups across pointer wrap; one EXC uop
        ready_i = 1'b1;
        for (int g = 0; g < 3; g++) begin
            lane_itype[2] = (g == 1) ? ITYPE_EXC : ITYPE_STD;
            issue(4'b1111, 32'hA0 + 32'(4 * g), 1'b1, 1'b0);
            step();
            step();
            step();
        end
        lane_itype[2] = ITYPE_STD;
        drain("drain_wrap");
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("disc_seen", 32'(disc_seen), 32'd1);

        // Reset mid-stream
        ready_i = 1'b0;
        issue(4'b1111, 32'hC0, 1'b1, 1'b0);
        issue(4'b0001, 32'hC4, 1'b1, 1'b0);
        chk("mid_cnt5", 32'(count_o), 32'd5);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        sb.delete();
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_count", 32'(count_o), 32'd0);
        chk("midrst_ovf", 32'(overflow_o), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
